// File: rtl/aes_mixcol_shared.sv
// Share-wise AES MixColumns/InvMixColumns: one output byte per cycle for every share.
// Four cycles of compute after input handshake; result is held with out_valid until out_ready is seen.
module aes_mixcol_shared #(
  parameter int NSHARES    = 2,
  parameter bit INVERSE_EN = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_mode,
  input  logic [32*NSHARES-1:0]   in_col,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [32*NSHARES-1:0]   out_col
);

  localparam int W = 32 * NSHARES;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]   r_state;
  logic [W-1:0] r_col;
  logic [W-1:0] r_out;
  logic         r_mode;
  logic [1:0]   r_cnt;
  logic [W-1:0] w_out_nxt;

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  for (genvar s = 0; s < NSHARES; s++) begin : g_share
    logic [31:0] w_sh;
    logic [31:0] w_rot;
    logic [31:0] w_nxt;
    logic [7:0]  w_x0, w_x1, w_x2, w_x3;
    logic [7:0]  w_x0_2, w_x1_2, w_x2_2, w_x3_2;
    logic [7:0]  w_fwd;
    logic [7:0]  w_b;

    assign w_sh = r_col[32*s +: 32];

    // Rotating by the byte counter lines a_i..a_(i+3) up in fixed slots for both modes.
    always_comb begin
      w_rot = w_sh;
      case (r_cnt)
        2'd0:    w_rot = w_sh;
        2'd1:    w_rot = {w_sh[23:0], w_sh[31:24]};
        2'd2:    w_rot = {w_sh[15:0], w_sh[31:16]};
        default: w_rot = {w_sh[7:0],  w_sh[31:8]};
      endcase
    end

    assign w_x0   = w_rot[31:24];
    assign w_x1   = w_rot[23:16];
    assign w_x2   = w_rot[15:8];
    assign w_x3   = w_rot[7:0];
    assign w_x0_2 = xt(w_x0);
    assign w_x1_2 = xt(w_x1);
    assign w_x2_2 = xt(w_x2);
    assign w_x3_2 = xt(w_x3);

    assign w_fwd = w_x0_2 ^ w_x1_2 ^ w_x1 ^ w_x2 ^ w_x3;

    if (INVERSE_EN) begin : g_inv
      logic [7:0] w_x0_4, w_x1_4, w_x2_4, w_x3_4;
      logic [7:0] w_x0_8, w_x1_8, w_x2_8, w_x3_8;
      logic [7:0] w_inv;
      assign w_x0_4 = xt(w_x0_2);
      assign w_x1_4 = xt(w_x1_2);
      assign w_x2_4 = xt(w_x2_2);
      assign w_x3_4 = xt(w_x3_2);
      assign w_x0_8 = xt(w_x0_4);
      assign w_x1_8 = xt(w_x1_4);
      assign w_x2_8 = xt(w_x2_4);
      assign w_x3_8 = xt(w_x3_4);
      // 0E*a_i ^ 0B*a_(i+1) ^ 0D*a_(i+2) ^ 09*a_(i+3)
      assign w_inv = (w_x0_8 ^ w_x0_4 ^ w_x0_2)
                   ^ (w_x1_8 ^ w_x1_2 ^ w_x1)
                   ^ (w_x2_8 ^ w_x2_4 ^ w_x2)
                   ^ (w_x3_8 ^ w_x3);
      assign w_b = r_mode ? w_inv : w_fwd;
    end else begin : g_fwd_only
      assign w_b = w_fwd;
    end

    always_comb begin
      w_nxt = r_out[32*s +: 32];
      case (r_cnt)
        2'd0:    w_nxt[31:24] = w_b;
        2'd1:    w_nxt[23:16] = w_b;
        2'd2:    w_nxt[15:8]  = w_b;
        default: w_nxt[7:0]   = w_b;
      endcase
    end

    assign w_out_nxt[32*s +: 32] = w_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_col   <= '0;
      r_out   <= '0;
      r_mode  <= 1'b0;
      r_cnt   <= 2'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_col   <= in_col;
            r_mode  <= INVERSE_EN ? in_mode : 1'b0;
            r_cnt   <= 2'd0;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          r_out <= w_out_nxt;
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign out_col   = r_out;

endmodule

// File: tb/tb_aes_mixcol_shared.sv
// Directed-vector and randomized bench for aes_mixcol_shared (2-share, 1-share forward-only, 3-share builds).
module tb_aes_mixcol_shared;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Main DUT: NSHARES=2, INVERSE_EN=1
  logic        in_valid, in_ready, in_mode, out_valid, out_ready;
  logic [63:0] in_col, out_col;

  // Forward-only unmasked build
  logic        in_valid_1, in_ready_1, in_mode_1, out_valid_1, out_ready_1;
  logic [31:0] in_col_1, out_col_1;

  // Three-share build for randomized traffic
  logic        in_valid_3, in_ready_3, in_mode_3, out_valid_3, out_ready_3;
  logic [95:0] in_col_3, out_col_3;

  aes_mixcol_shared #(.NSHARES(2), .INVERSE_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_col(in_col),
    .out_valid(out_valid), .out_ready(out_ready), .out_col(out_col)
  );

  aes_mixcol_shared #(.NSHARES(1), .INVERSE_EN(1'b0)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_1), .in_ready(in_ready_1), .in_mode(in_mode_1), .in_col(in_col_1),
    .out_valid(out_valid_1), .out_ready(out_ready_1), .out_col(out_col_1)
  );

  aes_mixcol_shared #(.NSHARES(3), .INVERSE_EN(1'b1)) dut3 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_3), .in_ready(in_ready_3), .in_mode(in_mode_3), .in_col(in_col_3),
    .out_valid(out_valid_3), .out_ready(out_ready_3), .out_col(out_col_3)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: generic shift-and-add GF(2^8) multiply
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [31:0] mixcol(input logic [31:0] w, input logic inv);
    logic [7:0] a [4];
    logic [7:0] c [4];
    logic [31:0] r = 32'h0;
    for (int k = 0; k < 4; k++) a[k] = w[31-8*k -: 8];
    if (inv) begin c[0] = 8'h0E; c[1] = 8'h0B; c[2] = 8'h0D; c[3] = 8'h09; end
    else     begin c[0] = 8'h02; c[1] = 8'h03; c[2] = 8'h01; c[3] = 8'h01; end
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b = 8'h00;
      for (int j = 0; j < 4; j++) b = b ^ gmul(a[(i+j)%4], c[j]);
      r[31-8*i -: 8] = b;
    end
    return r;
  endfunction

  typedef struct {
    logic [31:0] s0;
    logic [31:0] s1;
    logic        mode;
    logic [31:0] exp_xor;
  } vec_t;

  vec_t vecs [9];

  // Run one column through the 2-share DUT and drain it immediately.
  task automatic run2(input logic [63:0] col, input logic mode,
                      output logic [63:0] res, output int lat);
    in_col   = col;
    in_mode  = mode;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_mode  = ~mode;
    in_col   = {$urandom, $urandom};
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    res = out_col;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle_after_drain", {94'h0, in_ready, out_valid}, {94'h0, 2'b10});
  endtask

  logic [63:0] res, held;
  int          lat;
  logic [95:0] expq [$];
  int          got;
  int          cyc;

  initial begin
    vecs[0] = '{32'hDB135345 ^ 32'hA5C3F00F, 32'hA5C3F00F, 1'b0, 32'h8E4DA1BC};
    vecs[1] = '{32'hF20A225C, 32'h00000000, 1'b0, 32'h9FDC589D};
    vecs[2] = '{32'h8E4DA1BC, 32'h00000000, 1'b1, 32'hDB135345};
    vecs[3] = '{32'hC6C6C6C6, 32'h00000000, 1'b0, 32'hC6C6C6C6};
    vecs[4] = '{32'hC6C6C6C6, 32'h00000000, 1'b1, 32'hC6C6C6C6};
    vecs[5] = '{32'hD4D4D4D5, 32'h00000000, 1'b0, 32'hD5D5D7D6};
    vecs[6] = '{32'h2D26314C, 32'h00000000, 1'b0, 32'h4D7EBDF8};
    vecs[7] = '{32'h4D7EBDF8 ^ 32'h12345678, 32'h12345678, 1'b1, 32'h2D26314C};
    vecs[8] = '{32'h01010101, 32'h00000000, 1'b0, 32'h01010101};

    rst = 1'b1;
    in_valid = 1'b0; in_mode = 1'b0; in_col = '0; out_ready = 1'b0;
    in_valid_1 = 1'b0; in_mode_1 = 1'b0; in_col_1 = '0; out_ready_1 = 1'b0;
    in_valid_3 = 1'b0; in_mode_3 = 1'b0; in_col_3 = '0; out_ready_3 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {30'h0, in_ready, out_valid, out_col}, {30'h0, 1'b1, 1'b0, 64'h0});
    chk("reset_state_3", {out_col_3}, 96'h0);
    rst = 1'b0;

    // Directed vector table
    for (int v = 0; v < 9; v++) begin
      run2({vecs[v].s1, vecs[v].s0}, vecs[v].mode, res, lat);
      chk($sformatf("latency_v%0d", v), 96'(lat), 96'd4);
      chk($sformatf("xor_v%0d", v), 96'(res[31:0] ^ res[63:32]), 96'(vecs[v].exp_xor));
      chk($sformatf("shares_v%0d", v), 96'(res),
          96'({mixcol(vecs[v].s1, vecs[v].mode), mixcol(vecs[v].s0, vecs[v].mode)}));
    end

    // Backpressure in DONE: output held, in_valid pulses ignored
    in_col = {32'hA5C3F00F, 32'h7ED0A34A}; in_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("bp_latency", 96'(lat), 96'd4);
    held = out_col;
    chk("bp_xor", 96'(held[31:0] ^ held[63:32]), 96'h8E4DA1BC);
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0] ? 1'b0 : 1'b1;
      in_mode  = 1'b1;
      in_col   = {$urandom, $urandom};
      @(posedge clk); #1;
      chk($sformatf("bp_stable_%0d", k), 96'(out_col), 96'(held));
      chk($sformatf("bp_flags_%0d", k), {94'h0, out_valid, in_ready}, {94'h0, 2'b10});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release", {94'h0, in_ready, out_valid}, {94'h0, 2'b10});
    @(posedge clk); #1;
    chk("bp_not_consumed", {94'h0, in_ready, out_valid}, {94'h0, 2'b10});

    // Reset during the second BUSY cycle
    in_col = {32'h5A5A5A5A, 32'hF20A225C ^ 32'h5A5A5A5A}; in_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("partial_written", 96'(out_col[63:56] ^ out_col[31:24]), 96'h9F);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midop_reset", {30'h0, in_ready, out_valid, out_col}, {30'h0, 1'b1, 1'b0, 64'h0});
    repeat (6) @(posedge clk);
    #1;
    chk("midop_no_result", {95'h0, out_valid}, 96'h0);
    run2({32'h0F0F0F0F, 32'hDB135345 ^ 32'h0F0F0F0F}, 1'b0, res, lat);
    chk("post_reset_latency", 96'(lat), 96'd4);
    chk("post_reset_xor", 96'(res[31:0] ^ res[63:32]), 96'h8E4DA1BC);

    // Forward-only build ignores in_mode
    in_col_1 = 32'hDB135345; in_mode_1 = 1'b1; in_valid_1 = 1'b1;
    @(posedge clk); #1;
    in_valid_1 = 1'b0;
    lat = 0;
    while (!out_valid_1 && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("fwd_only_latency", 96'(lat), 96'd4);
    chk("fwd_only_result", 96'(out_col_1), 96'h8E4DA1BC);
    out_ready_1 = 1'b1;
    @(posedge clk); #1;
    out_ready_1 = 1'b0;
    chk("fwd_only_idle", {94'h0, in_ready_1, out_valid_1}, {94'h0, 2'b10});

    // Randomized 3-share traffic with valid/ready gaps
    got = 0;
    cyc = 0;
    fork
      begin : driver
        for (int n = 0; n < 1000; n++) begin
          logic [95:0] c;
          logic        m;
          int          w;
          c = {$urandom, $urandom, $urandom};
          m = 1'($urandom_range(0, 1));
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
          in_col_3 = c; in_mode_3 = m; in_valid_3 = 1'b1;
          w = 0;
          forever begin
            @(negedge clk);
            if (in_ready_3 || w >= 50) break;
            w++;
          end
          if (w >= 50) begin
            failures++;
            $display("FAIL rand_accept_timeout: got no in_ready required in_ready within 50 cycles");
            in_valid_3 = 1'b0;
            break;
          end
          expq.push_back({mixcol(c[95:64], m), mixcol(c[63:32], m), mixcol(c[31:0], m)});
          @(posedge clk); #1;
          in_valid_3 = 1'b0;
          in_mode_3  = ~m;
        end
      end
      begin : consumer
        while (got < 1000 && cyc < 30000) begin
          @(posedge clk); #1;
          out_ready_3 = ($urandom_range(0, 2) != 0);
          @(negedge clk);
          cyc++;
          if (out_valid_3 && out_ready_3) begin
            if (expq.size() == 0) begin
              chk("rand_unexpected_out", out_col_3, 96'hx);
            end else begin
              chk("rand_col", out_col_3, expq.pop_front());
            end
            got++;
          end
        end
        out_ready_3 = 1'b0;
      end
    join
    chk("rand_count", 96'(got), 96'd1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_mixcol_shared.md
Name: aes_mixcol_shared

Overview:
- Byte-serial, share-wise AES MixColumns / InvMixColumns unit for the masked datapath.
- Built on GF(2^8) multiply-by-2 (xtime, reduction polynomial 0x11B) and its compositions.
- Accepts one 32-bit column per share for NSHARES Boolean shares and computes one output byte per cycle over 4 cycles.
- The operation is linear, so each share is processed independently and no share mixing ever occurs.
- Sits between ShiftRows and AddRoundKey in the round datapath.

Parameters:
- NSHARES, 2, number of Boolean shares (>=1); every share uses identical logic.
- INVERSE_EN, 1, 1 = mode input selects InvMixColumns; 0 = inverse logic not built, mode ignored, always forward.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input column valid.
- in_ready  out  1  unit can accept a column.
- in_mode  in  1  0 = MixColumns, 1 = InvMixColumns; sampled at input handshake.
- in_col  in  32*NSHARES  share s at bits [32*s+31:32*s]; within a share, byte a0 = [31:24], a1 = [23:16], a2 = [15:8], a3 = [7:0].
- out_valid  out  1  result column valid.
- out_ready  in  1  consumer accepts result.
- out_col  out  32*NSHARES  result, same packing as in_col.

Behaviour:
- Reset (rst high at a clock edge):
  - FSM -> IDLE; out_valid = 0; in_ready = 1 in the following cycle.
  - Internal column registers, mode register, byte counter and out_col all cleared to 0, so no stale share data remains.
  - Reset overrides any handshake in the same cycle and aborts a BUSY or DONE operation; the aborted result is never presented.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid=1 at an edge: latch in_col per share and in_mode (forced 0 if INVERSE_EN=0), clear byte counter i to 0, go to BUSY.
- BUSY:
  - in_ready = 0, out_valid = 0.
  - Each edge computes output byte b_i for every share and writes it into the output register at byte position i, then increments i.
  - On the edge where i=3 is written: go to DONE.
- DONE:
  - out_valid = 1, in_ready = 0.
  - out_col stays stable until out_valid & out_ready at an edge, then go to IDLE.
  - No new column is accepted in the handshake cycle; throughput is 1 column per 6 cycles minimum.
- Latency: handshake at edge E0, out_valid = 1 in the cycle after edge E4.
- Arithmetic, per share, indices mod 4:
  - Forward: b_i = 02*a_i ^ 03*a_(i+1) ^ a_(i+2) ^ a_(i+3).
  - Inverse: b_i = 0E*a_i ^ 0B*a_(i+1) ^ 0D*a_(i+2) ^ 09*a_(i+3).
  - All constant multiplies built from chained xtime and XOR only: 03 = 02^01, 09 = 08^01, 0B = 08^02^01, 0D = 08^04^01, 0E = 08^04^02.
  - No lookup tables.
- A single byte-rotation mux selects a_i..a_(i+3) from counter i; that mux is shared across modes.
- in_mode changes while BUSY or DONE have no effect.
- in_valid while not IDLE is ignored; the data is not consumed.
- out_col is registered; no combinational path from any input to any output.
- NSHARES=1 gives an unmasked reference implementation with identical timing.

Test Plan:
- Forward, NSHARES=2: share0 = DB135345 ^ A5C3F00F, share1 = A5C3F00F, mode 0 -> out_valid 4 cycles after handshake. XOR of output shares = 8E4DA1BC, and each output share equals MixColumns of its own input share.
- Forward F20A225C (share1 = 0) -> 9FDC589D. Inverse mode on 8E4DA1BC (share1 = 0) -> DB135345; column C6C6C6C6 in either mode -> C6C6C6C6.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_col stable, out_valid held at 1, in_ready stays 0, in_valid pulses ignored. Raise out_ready -> IDLE next cycle, in_ready = 1.
- Reset mid-operation: assert rst at the 2nd BUSY cycle -> next cycle FSM is IDLE, out_valid = 0, out_col = 0. A fresh column afterwards gives the correct result with nominal latency.
- INVERSE_EN=0 build: in_mode=1 with column DB135345 -> 8E4DA1BC (forward result). NSHARES=3 random columns checked against the software model, share-wise, over 1000 transactions with random valid/ready gaps.
